// File: rtl/fifo_reg_dual.sv
// fifo_reg_dual: single-clock, register-based FIFO for the USB3300 sniffer
// capture path. It supports simultaneous read and write, any depth >= 2,
// registered or first-word-fall-through read, an occupancy output, a
// synchronous flush and sticky overflow/underflow flags.
//
// Handshake: a write is taken on a rising clk edge when wr_dv=1 and wr_full=0.
// A read is taken on a rising clk edge when rd_en=1 and rd_empty=0. Both
// decisions use the state before the edge and can be taken in the same cycle.
// A request made against a full or empty FIFO is dropped and sets the sticky
// overflow or underflow flag. rd_valid qualifies rd_DATA. In registered mode
// it pulses for one cycle after each accepted read. In FWFT mode it follows
// ~rd_empty, and rd_en pops the word that is currently on rd_DATA.
module fifo_reg_dual #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_DEPTH       = 16,
  parameter int ALMOST_FULL_VAL  = 12,
  parameter int ALMOST_EMPTY_VAL = 4,
  parameter int FWFT             = 0,
  localparam int LW              = $clog2(DATA_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_dv,
  input  logic [DATA_WIDTH-1:0] wr_DATA,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_DATA,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int          PW    = $clog2(DATA_DEPTH);
  localparam logic [31:0] AF_U  = ALMOST_FULL_VAL;
  localparam logic [31:0] AE_U  = ALMOST_EMPTY_VAL;
  localparam logic [PW-1:0] LAST = PW'(DATA_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // The pointers wrap explicitly at DATA_DEPTH-1, so a depth that is not a
  // power of two works without relying on binary rollover.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // The status flags are decoded from the occupancy count alone.
  always_comb begin
    level           = level_q;
    wr_full         = (level_q == LW'(DATA_DEPTH));
    rd_empty        = (level_q == '0);
    wr_almost_full  = (32'(level_q) >= AF_U);
    rd_almost_empty = (32'(level_q) <= AE_U);
  end

  // Accept decisions. Flush masks both sides for the cycle it is asserted.
  always_comb begin
    wr_acc = ~flush & wr_dv & ~wr_full;
    rd_acc = ~flush & rd_en & ~rd_empty;
  end

  // The storage array is not reset. Only slots below level are ever observed.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_DATA;
  end

  // Pointers and occupancy. Flush returns the FIFO to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      level_q <= level_q + LW'(wr_acc) - LW'(rd_acc);
    end
  end

  // Sticky error flags. If a new error arrives in the same cycle as clr_err,
  // the flag is set. Flush suppresses new error events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (~flush & wr_dv & wr_full);
      underflow <= (underflow & ~clr_err) | (~flush & rd_en & rd_empty);
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Registered read. Data lands one edge after the pop and is then held.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_DATA  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
      // The head word is always shown on rd_DATA. rd_en acknowledges it.
      assign rd_DATA  = mem[rd_ptr];
      assign rd_valid = ~rd_empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_reg_dual.sv
// tb_fifo_reg_dual: directed bench for fifo_reg_dual. It drives a default
// registered-read instance (depth 16) and an FWFT instance (depth 6). Both are
// checked every cycle against queue-based reference models.
module tb_fifo_reg_dual;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance 0: registered read, depth 16 ----------------
  logic       f0 = 0, c0 = 0, w0 = 0, r0 = 0;
  logic [7:0] wd0 = '0;
  logic       full0, afull0, rv0, emp0, aemp0, ov0, un0;
  logic [7:0] rdd0;
  logic [4:0] lvl0;

  fifo_reg_dual u_dut0 (
    .clk(clk), .rst(rst), .flush(f0), .clr_err(c0),
    .wr_dv(w0), .wr_DATA(wd0), .wr_full(full0), .wr_almost_full(afull0),
    .rd_en(r0), .rd_DATA(rdd0), .rd_valid(rv0), .rd_empty(emp0),
    .rd_almost_empty(aemp0), .level(lvl0), .overflow(ov0), .underflow(un0)
  );

  // ---------------- instance 1: FWFT, depth 6 ----------------
  logic       f1 = 0, c1 = 0, w1 = 0, r1 = 0;
  logic [7:0] wd1 = '0;
  logic       full1, afull1, rv1, emp1, aemp1, ov1, un1;
  logic [7:0] rdd1;
  logic [2:0] lvl1;

  fifo_reg_dual #(
    .DATA_WIDTH(8), .DATA_DEPTH(6), .ALMOST_FULL_VAL(4),
    .ALMOST_EMPTY_VAL(1), .FWFT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .flush(f1), .clr_err(c1),
    .wr_dv(w1), .wr_DATA(wd1), .wr_full(full1), .wr_almost_full(afull1),
    .rd_en(r1), .rd_DATA(rdd1), .rd_valid(rv1), .rd_empty(emp1),
    .rd_almost_empty(aemp1), .level(lvl1), .overflow(ov1), .underflow(un1)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] m_data0  = '0;
  logic       m_valid0 = 1'b0;
  logic       m_ov0 = 1'b0, m_un0 = 1'b0, m_ov1 = 1'b0, m_un1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a queue. Requests are judged on its size before the edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q0.delete(); exp_q1.delete();
      m_data0 = '0; m_valid0 = 1'b0;
      m_ov0 = 1'b0; m_un0 = 1'b0; m_ov1 = 1'b0; m_un1 = 1'b0;
    end else begin
      // instance 0
      if (f0) begin
        exp_q0.delete();
        m_valid0 = 1'b0;
        m_ov0 = m_ov0 & ~c0;
        m_un0 = m_un0 & ~c0;
      end else begin
        automatic bit fl = (exp_q0.size() == 16);
        automatic bit em = (exp_q0.size() == 0);
        m_ov0 = (m_ov0 & ~c0) | (w0 & fl);
        m_un0 = (m_un0 & ~c0) | (r0 & em);
        m_valid0 = 1'b0;
        if (r0 && !em) begin
          m_data0  = exp_q0.pop_front();
          m_valid0 = 1'b1;
        end
        if (w0 && !fl) exp_q0.push_back(wd0);
      end
      // instance 1
      if (f1) begin
        exp_q1.delete();
        m_ov1 = m_ov1 & ~c1;
        m_un1 = m_un1 & ~c1;
      end else begin
        automatic bit fl = (exp_q1.size() == 6);
        automatic bit em = (exp_q1.size() == 0);
        m_ov1 = (m_ov1 & ~c1) | (w1 & fl);
        m_un1 = (m_un1 & ~c1) | (r1 & em);
        if (r1 && !em) void'(exp_q1.pop_front());
        if (w1 && !fl) exp_q1.push_back(wd1);
      end
    end
  end

  // Compare process: all DUT outputs against the model, on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("lvl0",   32'(lvl0),   exp_q0.size());
      check("full0",  32'(full0),  32'(exp_q0.size() == 16));
      check("afull0", 32'(afull0), 32'(exp_q0.size() >= 12));
      check("emp0",   32'(emp0),   32'(exp_q0.size() == 0));
      check("aemp0",  32'(aemp0),  32'(exp_q0.size() <= 4));
      check("ov0",    32'(ov0),    32'(m_ov0));
      check("un0",    32'(un0),    32'(m_un0));
      check("rv0",    32'(rv0),    32'(m_valid0));
      check("rdd0",   32'(rdd0),   32'(m_data0));
      check("lvl1",   32'(lvl1),   exp_q1.size());
      check("full1",  32'(full1),  32'(exp_q1.size() == 6));
      check("afull1", 32'(afull1), 32'(exp_q1.size() >= 4));
      check("emp1",   32'(emp1),   32'(exp_q1.size() == 0));
      check("aemp1",  32'(aemp1),  32'(exp_q1.size() <= 1));
      check("ov1",    32'(ov1),    32'(m_ov1));
      check("un1",    32'(un1),    32'(m_un1));
      check("rv1",    32'(rv1),    32'(exp_q1.size() != 0));
      if (exp_q1.size() != 0) check("rdd1", 32'(rdd1), 32'(exp_q1[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc0(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    @(negedge clk);
    w0 = w; wd0 = d; r0 = r; f0 = f; c0 = c;
  endtask

  task automatic cyc1(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    @(negedge clk);
    w1 = w; wd1 = d; r1 = r; f1 = f; c1 = c;
  endtask

  task automatic idle0();
    cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle1();
    cyc1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_lvl0",   32'(lvl0),   32'd0);
    check("rst_emp0",   32'(emp0),   32'd1);
    check("rst_aemp0",  32'(aemp0),  32'd1);
    check("rst_afull0", 32'(afull0), 32'd0);
    check("rst_rdd0",   32'(rdd0),   32'h00);
    check("rst_rv1",    32'(rv1),    32'd0);
    rst = 1'b1;

    // 15 words in, then 15 back-to-back reads
    for (int i = 0; i < 15; i++) cyc0(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle0();
    check("fill15_lvl",   32'(lvl0),   32'd15);
    check("fill15_afull", 32'(afull0), 32'd1);
    check("fill15_full",  32'(full0),  32'd0);
    for (int i = 0; i < 15; i++) begin
      cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (i > 0) check("rd_seq", 32'({rv0, rdd0}), 32'({1'b1, 8'h11 + 8'(i - 1)}));
    end
    idle0();
    check("rd_last", 32'(rdd0), 32'h1F);
    check("rd_emp",  32'(emp0), 32'd1);
    idle0();
    check("rv_pulse_end", 32'(rv0), 32'd0);

    // Fill to 16, then a 17th write is dropped
    for (int i = 0; i < 16; i++) cyc0(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    idle0();
    check("ovf_full", 32'(full0), 32'd1);
    check("ovf_flag", 32'(ov0),   32'd1);
    check("ovf_lvl",  32'(lvl0),  32'd16);
    idle0();
    check("ovf_sticky", 32'(ov0), 32'd1);
    cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle0();
    check("ovf_clr", 32'(ov0), 32'd0);

    // Full with write+read: the read wins and the write overflows
    cyc0(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
    idle0();
    check("sim_full_lvl", 32'(lvl0), 32'd15);
    check("sim_full_ov",  32'(ov0),  32'd1);
    check("sim_full_rd",  32'(rdd0), 32'h30);
    cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // 40 cycles of write+read at level 8
    for (int i = 0; i < 40; i++) cyc0(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
    idle0();
    check("sim8_lvl",  32'(lvl0), 32'd8);
    check("sim8_last", 32'(rdd0), 32'h9F);
    for (int i = 0; i < 8; i++) cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle0();
    check("drain_last", 32'(rdd0), 32'hA7);
    check("drain_emp",  32'(emp0), 32'd1);

    // Underflow, then write+read on an empty FIFO, then flush with wr_dv
    cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle0();
    check("unf_flag", 32'(un0),  32'd1);
    check("unf_lvl",  32'(lvl0), 32'd0);
    cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc0(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    idle0();
    check("emp_wr_rd_un",  32'(un0),  32'd1);
    check("emp_wr_rd_lvl", 32'(lvl0), 32'd1);
    check("emp_wr_rd_rv",  32'(rv0),  32'd0);
    cyc0(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 8'h57, 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    idle0();
    check("flush_lvl", 32'(lvl0), 32'd0);
    check("flush_un",  32'(un0),  32'd1);
    check("flush_rdd", 32'(rdd0), 32'hA7);

    // Asynchronous reset with traffic in flight (level 5, rd_valid high)
    for (int i = 0; i < 6; i++) cyc0(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_lvl", 32'(lvl0), 32'd5);
    check("pre_rst_rv",  32'(rv0),  32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_lvl", 32'(lvl0), 32'd0);
    check("arst_emp", 32'(emp0), 32'd1);
    check("arst_rv",  32'(rv0),  32'd0);
    check("arst_un",  32'(un0),  32'd0);
    idle0();
    @(negedge clk);
    rst = 1'b1;

    // FWFT instance: the head word is visible without rd_en
    cyc1(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    idle1();
    check("fwft_data",  32'(rdd1), 32'hA0);
    check("fwft_valid", 32'(rv1),  32'd1);
    check("fwft_lvl",   32'(lvl1), 32'd1);
    // Stream 20 words. Pop in 4 of every 5 cycles, so the level grows to 5 and pointers wrap.
    for (int i = 0; i < 20; i++)
      cyc1(1'b1, 8'hB0 + 8'(i), (i % 5) != 0, 1'b0, 1'b0);
    idle1();
    check("stream_lvl",  32'(lvl1), 32'd5);
    check("stream_head", 32'(rdd1), 32'hBF);
    for (int i = 0; i < 5; i++) cyc1(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle1();
    check("stream_emp", 32'(emp1), 32'd1);
    check("stream_rv",  32'(rv1),  32'd0);
    for (int i = 0; i < 7; i++) cyc1(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle1();
    check("d6_full", 32'(full1), 32'd1);
    check("d6_lvl",  32'(lvl1),  32'd6);
    check("d6_ov",   32'(ov1),   32'd1);
    check("d6_head", 32'(rdd1),  32'hD0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
